// File: rtl/dma_mem_responder_if.sv
// Wishbone classic bus between the DMA master port and the memory responder.
// Signal names follow the slave-side (wbs_*) view used by the user project.
interface dma_mem_responder_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Wishbone classic slave backing a word-addressed buffer with fixed read/write ack latency.
// Optional one-word read prefetch buffer enabled by defining DMA_MEM_PREFETCH_EN.
module dma_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 3,
    parameter int unsigned WRITE_LAT   = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    dma_mem_responder_if.slave  wbs
);

    localparam int unsigned  IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0]  WIN_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]   RD_CNT    = 4'(READ_LAT - 1);
    localparam logic [3:0]   WR_CNT    = 4'(WRITE_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req;
    logic [31:0]        offset;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               commit;
    logic               pf_hit;
    logic [31:0]        pf_rdata;

    assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign offset  = wbs.wbs_adr_i - BASE_ADDR;
    assign hit     = req & (offset < WIN_BYTES);
    assign hit_idx = offset[IDX_W+1:2];
    assign commit  = (state_q == ACK) & we_q;

`ifdef DMA_MEM_PREFETCH_EN
    logic               pf_valid_q, pf_valid_d;
    logic [IDX_W-1:0]   pf_idx_q, pf_idx_d;
    logic [31:0]        pf_data_q, pf_data_d;
    logic [IDX_W-1:0]   idx_inc;

    assign idx_inc  = idx_q + IDX_W'(1);
    assign pf_hit   = (state_q == IDLE) & hit & ~wbs.wbs_we_i & pf_valid_q & (hit_idx == pf_idx_q);
    assign pf_rdata = pf_data_q;

    // A read ack stages the following word; writes landing on it keep the copy coherent.
    always_comb begin
        pf_valid_d = pf_valid_q;
        pf_idx_d   = pf_idx_q;
        pf_data_d  = pf_data_q;
        if ((state_q == ACK) && !we_q) begin
            pf_valid_d = (idx_q != {IDX_W{1'b1}});
            pf_idx_d   = idx_inc;
            pf_data_d  = mem_q[idx_inc];
        end else if (commit && (idx_q == pf_idx_q)) begin
            pf_data_d  = merge_bytes(pf_data_q, wdat_q, sel_q);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) pf_valid_q <= 1'b0;
        else          pf_valid_q <= pf_valid_d;
    end

    always_ff @(posedge wb_clk_i) begin
        pf_idx_q  <= pf_idx_d;
        pf_data_q <= pf_data_d;
    end
`else
    assign pf_hit   = 1'b0;
    assign pf_rdata = 32'h0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are latched at accept; later bus changes are ignored until the ack.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    we_d   = wbs.wbs_we_i;
                    idx_d  = hit_idx;
                    sel_d  = wbs.wbs_sel_i;
                    wdat_d = wbs.wbs_dat_i;
                    cnt_d  = wbs.wbs_we_i ? WR_CNT : RD_CNT;
                    if (pf_hit) begin
                        state_d   = ACK;
                        cnt_d     = 4'h0;
                        rd_data_d = pf_rdata;
                    end else if (cnt_d == 4'h0) begin
                        state_d   = ACK;
                        rd_data_d = mem_q[hit_idx];
                    end else begin
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'h0;
                end else if (cnt_q == 4'h1) begin
                    state_d   = ACK;
                    cnt_d     = 4'h0;
                    rd_data_d = mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbs.wbs_ack_o = (state_q == ACK);
        wbs.wbs_dat_o = ((state_q == ACK) && !we_q) ? rd_data_q : 32'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        we_q      <= we_d;
        idx_q     <= idx_d;
        sel_q     <= sel_d;
        wdat_q    <= wdat_d;
        rd_data_q <= rd_data_d;
    end

    // Writes land on the edge that ends the ack cycle, so a reset during ACK discards them.
    always_ff @(posedge wb_clk_i) begin
        if (commit) mem_q[idx_q] <= merge_bytes(mem_q[idx_q], wdat_q, sel_q);
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: latency, byte enables, window, abort, reset, prefetch.
module tb_dma_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    dma_mem_responder_if bus();

    dma_mem_responder dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
    endtask

    // Request goes up mid-cycle T; ack latency is counted in rising edges after that.
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int exp_lat, input logic [31:0] exp_dat);
        int   k;
        logic seen;
        @(negedge clk);
        drive(we, adr, dat, sel);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (bus.wbs_ack_o === 1'b1) seen = 1'b1;
        end
        check({tag, " latency"}, k, exp_lat);
        check({tag, " data"}, bus.wbs_dat_o, exp_dat);
        idle_bus();
        @(posedge clk);
        @(negedge clk);
        check({tag, " ack width"}, {31'b0, bus.wbs_ack_o}, 32'h0);
    endtask

    initial begin
        logic bad_ack;
        logic bad_dat;
        int   lat_pf;

        idle_bus();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", {31'b0, bus.wbs_ack_o}, 32'h0);
        check("reset dat", bus.wbs_dat_o, 32'h0);
        rst = 1'b0;

        // Abort: stb dropped while waiting on a read
        xfer("seed 10C", 1'b1, 32'h3800_010C, 32'hCAFE_F00D, 4'hF, 1, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h3800_010C, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        bus.wbs_stb_i = 1'b0;
        bad_ack = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wbs_ack_o !== 1'b0) bad_ack = 1'b1;
        end
        check("abort no ack", {31'b0, bad_ack}, 32'h0);
        idle_bus();
        xfer("read after abort", 1'b0, 32'h3800_010C, 32'h0, 4'h0, 3, 32'hCAFE_F00D);

        // Full-word write then read back
        xfer("write DEADBEEF", 1'b1, 32'h3800_0100, 32'hDEAD_BEEF, 4'hF, 1, 32'h0);
        xfer("read DEADBEEF", 1'b0, 32'h3800_0100, 32'h0, 4'h0, 3, 32'hDEAD_BEEF);

        // Single byte lane write
        xfer("write lane1", 1'b1, 32'h3800_0100, 32'h0000_AB00, 4'b0010, 1, 32'h0);
        xfer("read merged", 1'b0, 32'h3800_0100, 32'h0, 4'h0, 3, 32'hDEAD_ABEF);

        // Out-of-window request is never accepted
        @(negedge clk);
        drive(1'b0, 32'h3000_0000, 32'h0, 4'h0);
        bad_ack = 1'b0;
        bad_dat = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wbs_ack_o !== 1'b0) bad_ack = 1'b1;
            if (bus.wbs_dat_o !== 32'h0) bad_dat = 1'b1;
        end
        check("oow no ack", {31'b0, bad_ack}, 32'h0);
        check("oow dat zero", {31'b0, bad_dat}, 32'h0);
        xfer("read after oow", 1'b0, 32'h3800_0100, 32'h0, 4'h0, 3, 32'hDEAD_ABEF);

        // Reset during a write's ack cycle discards the write
        xfer("seed 108", 1'b1, 32'h3800_0108, 32'h1111_2222, 4'hF, 1, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h3800_0108, 32'h9999_9999, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_bus();
        @(negedge clk);
        check("rst drops ack", {31'b0, bus.wbs_ack_o}, 32'h0);
        check("rst dat zero", bus.wbs_dat_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer("read after rst", 1'b0, 32'h3800_0108, 32'h0, 4'h0, 3, 32'h1111_2222);

        // Sequential reads with an intervening write to the next word
`ifdef DMA_MEM_PREFETCH_EN
        lat_pf = 1;
`else
        lat_pf = 3;
`endif
        xfer("seq read 100", 1'b0, 32'h3800_0100, 32'h0, 4'h0, 3, 32'hDEAD_ABEF);
        xfer("write 104", 1'b1, 32'h3800_0104, 32'h1234_5678, 4'hF, 1, 32'h0);
        xfer("seq read 104", 1'b0, 32'h3800_0104, 32'h0, 4'h0, lat_pf, 32'h1234_5678);
        xfer("seq read 108", 1'b0, 32'h3800_0108, 32'h0, 4'h0, lat_pf, 32'h1111_2222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
